multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control unit for the multicycle ARM datapath; successor to the single-cycle decoder.
//  Sequences each instruction through a Moore FSM: FETCH, DECODE, then execute/memory/writeback states.
//  Adds a registered NZCV flag file, condition-code evaluation, CMP/TST (no-writeback) and optional EOR.
//  Sits between the instruction register and the datapath mux/enable controls.
// PARAMETERS
//  ALUCTL_W  2  ALUControl width; 3 enables EOR (ALUControl=3'b100).
//  FLAG_RST  4'b0000  reset value of the NZCV flag register.
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         synchronous, active-high reset
//  Cond       in   4         Instr[31:28]
//  Op         in   2         Instr[27:26]
//  Funct      in   6         Instr[25:20]
//  Rd         in   4         Instr[15:12]
//  ALUFlags   in   4         {N,Z,C,V} from the ALU, current cycle
//  PCWrite    out  1         PC register enable
//  AdrSrc     out  1         memory address: 0=PC, 1=ALUOut
//  MemW       out  1         data memory write enable
//  IRWrite    out  1         instruction register enable
//  RegW       out  1         register file write enable
//  ALUSrcA    out  1         0=RD1 register, 1=PC
//  ALUSrcB    out  2         00=RD2, 01=ExtImm, 10=constant 4
//  ResultSrc  out  2         00=ALUOut, 01=Data, 10=ALU result
//  ImmSrc     out  2         combinational: Op (00 imm8, 01 imm12, 10 imm24)
//  RegSrc     out  2         combinational: [0]=Op==10, [1]=Op==01 & ~Funct[0]
//  ALUControl out  ALUCTL_W  ALU operation
//  Illegal    out  1         one-cycle pulse in DECODE for an unsupported encoding
// BEHAVIOUR
//  State register: 4 bits. Reset gives state FETCH and flags FLAG_RST.
//  All outputs reflect FETCH decode on the cycle after reset.
//  Transitions:
//   FETCH -> DECODE.
//   DECODE -> MEMADR (Op=01), EXECR (Op=00, ~Funct[5]), EXECI (Op=00, Funct[5]), BRANCH (Op=10).
//   DECODE -> FETCH for Op=11 or an unsupported cmd; Illegal=1 for that cycle.
//   MEMADR -> MEMRD (Funct[0]=1) or MEMWR. MEMRD -> MEMWB.
//   MEMWB, MEMWR, ALUWB, BRANCH -> FETCH. EXECR, EXECI -> ALUWB.
//  Latency: data-processing = 4 cycles, LDR = 5, STR = 4, B = 3.
//  State outputs (unlisted outputs are 0 or 00):
//   FETCH:  IRWrite=1, PCWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD.
//   DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD.
//   MEMADR: ALUSrcB=01, ADD (U bit ignored).
//   MEMRD:  AdrSrc=1.
//   MEMWB:  ResultSrc=01, RegW=CondEx.
//   MEMWR:  AdrSrc=1, MemW=CondEx.
//   EXECR:  ALUSrcB=00, ALUControl from cmd.
//   EXECI:  ALUSrcB=01, ALUControl from cmd.
//   ALUWB:  RegW=CondEx & ~NoWrite.
//   BRANCH: ALUSrcB=01, ResultSrc=10, ADD, PCWrite=CondEx.
//  Rd==15 writeback (MEMWB, ALUWB): PCWrite=RegW. The register-file RegW stays 0.
//  cmd=Funct[4:1], S=Funct[0]. FlagW[1]=NZ, FlagW[0]=CV.
//   ADD 0100: 00, FlagW=11 if S.
//   SUB 0010: 01, FlagW=11 if S.
//   AND 0000: 10, FlagW=10 if S.
//   ORR 1100: 11, FlagW=10 if S.
//   CMP 1010: SUB, FlagW=11, NoWrite=1; S=0 is illegal.
//   TST 1000: AND, FlagW=10, NoWrite=1; S=0 is illegal.
//   EOR 0001: 100, FlagW=10 if S; legal only when ALUCTL_W=3, otherwise illegal.
//  Flags register updates only at the end of EXECR/EXECI: bits selected by FlagW, gated by CondEx.
//  CondEx is combinational from Cond and the registered flags. Conditions:
//   EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE follow standard ARM meaning.
//   AL=1. 1111 gives CondEx=0; the instruction completes with no writes.
//  Reset during any state: next state is FETCH and flags return to FLAG_RST. No write enable fires that cycle.
// TESTING
//  Reset, then idle: FETCH (IRWrite=1, PCWrite=1), then DECODE, in that order.
//  ADDS, Funct=101001, Cond=1110, ALUFlags=0100 -> cycle 4 RegW=1; flags Z=1 after EXECI.
//  SUBS, Funct=000101, ALUFlags=1000, CondEx=1 -> flags become 1000.
//  BEQ after Z=1: 3 cycles, PCWrite=1 in BRANCH.
//  Same BEQ with Z=0: PCWrite=0 in BRANCH.
//  LDR (Op=01, Funct[0]=1): 5 cycles, RegW=1 in MEMWB.
//  LDR with Rd=15: PCWrite=1 and RegW=0 in MEMWB.
//  STR with Cond=0001 and Z=1: 4 cycles, MemW=0 throughout.
//  CMP Funct=010101 vs TST Funct=010001: ALUControl 01 / 10; flags updated; RegW=0 in ALUWB.
//  Op=11 -> Illegal=1 in DECODE, FETCH next.
//  EOR with ALUCTL_W=2 -> Illegal=1 in DECODE.
//  reset asserted in MEMWR -> MemW=0, FETCH next cycle, flags=FLAG_RST.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: Moore FSM over fetch/decode/execute states with a registered NZCV flag file.
// Data-processing 4 cycles, LDR 5, STR 4, B 3; one state per clock, no stall input.
module multicycle_controller #(
  parameter int         ALUCTL_W = 2,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          Cond,
  input  logic [1:0]          Op,
  input  logic [5:0]          Funct,
  input  logic [3:0]          Rd,
  input  logic [3:0]          ALUFlags,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                MemW,
  output logic                IRWrite,
  output logic                RegW,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          RegSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                Illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  typedef struct packed {
    logic                pcwrite;
    logic                adrsrc;
    logic                memw;
    logic                irwrite;
    logic                regw;
    logic                alusrca;
    logic [1:0]          alusrcb;
    logic [1:0]          resultsrc;
    logic [ALUCTL_W-1:0] alucontrol;
  } ctrl_t;

  state_t              r_state;
  ctrl_t               r_ctrl;
  logic [3:0]          r_flags;

  state_t              w_next;
  logic                w_condex;
  logic                w_n, w_z, w_c, w_v;
  logic [3:0]          w_cmd;
  logic                w_s;
  logic                w_dp_legal;
  logic                w_legal;
  logic                w_nowrite;
  logic                w_rd15;
  logic [1:0]          w_flagw;
  logic [ALUCTL_W-1:0] w_aluctl;

  always_comb begin
    {w_n, w_z, w_c, w_v} = r_flags;
    case (Cond)
      4'b0000: w_condex = w_z;
      4'b0001: w_condex = ~w_z;
      4'b0010: w_condex = w_c;
      4'b0011: w_condex = ~w_c;
      4'b0100: w_condex = w_n;
      4'b0101: w_condex = ~w_n;
      4'b0110: w_condex = w_v;
      4'b0111: w_condex = ~w_v;
      4'b1000: w_condex = w_c & ~w_z;
      4'b1001: w_condex = ~w_c | w_z;
      4'b1010: w_condex = (w_n == w_v);
      4'b1011: w_condex = (w_n != w_v);
      4'b1100: w_condex = ~w_z & (w_n == w_v);
      4'b1101: w_condex = w_z | (w_n != w_v);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  assign w_cmd  = Funct[4:1];
  assign w_s    = Funct[0];
  assign w_rd15 = (Rd == 4'd15);

  always_comb begin
    w_aluctl   = '0;
    w_flagw    = 2'b00;
    w_nowrite  = 1'b0;
    w_dp_legal = 1'b1;
    case (w_cmd)
      4'b0100: begin
        w_aluctl = ALUCTL_W'(2'b00);
        w_flagw  = w_s ? 2'b11 : 2'b00;
      end
      4'b0010: begin
        w_aluctl = ALUCTL_W'(2'b01);
        w_flagw  = w_s ? 2'b11 : 2'b00;
      end
      4'b0000: begin
        w_aluctl = ALUCTL_W'(2'b10);
        w_flagw  = {w_s, 1'b0};
      end
      4'b1100: begin
        w_aluctl = ALUCTL_W'(2'b11);
        w_flagw  = {w_s, 1'b0};
      end
      // Compare/test only exist in their flag-setting form
      4'b1010: begin
        w_aluctl   = ALUCTL_W'(2'b01);
        w_flagw    = 2'b11;
        w_nowrite  = 1'b1;
        w_dp_legal = w_s;
      end
      4'b1000: begin
        w_aluctl   = ALUCTL_W'(2'b10);
        w_flagw    = 2'b10;
        w_nowrite  = 1'b1;
        w_dp_legal = w_s;
      end
      4'b0001: begin
        w_aluctl   = ALUCTL_W'(3'b100);
        w_flagw    = {w_s, 1'b0};
        w_dp_legal = (ALUCTL_W >= 3);
      end
      default: w_dp_legal = 1'b0;
    endcase
  end

  assign w_legal = (Op == 2'b01) || (Op == 2'b10) || ((Op == 2'b00) && w_dp_legal);

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_legal) begin
          case (Op)
            2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
            2'b01:   w_next = S_MEMADR;
            2'b10:   w_next = S_BRANCH;
            default: w_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // Control word for the state being entered; writeback to r15 is steered to PCWrite.
  function automatic ctrl_t state_ctrl(input state_t s, input logic condex, input logic nowrite,
                                       input logic rd15, input logic [ALUCTL_W-1:0] alu);
    ctrl_t c;
    logic  wb;
    c  = '0;
    wb = 1'b0;
    case (s)
      S_FETCH: begin
        c.irwrite   = 1'b1;
        c.pcwrite   = 1'b1;
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      S_DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      S_MEMADR: c.alusrcb = 2'b01;
      S_MEMRD:  c.adrsrc  = 1'b1;
      S_MEMWB: begin
        c.resultsrc = 2'b01;
        wb          = condex;
      end
      S_MEMWR: begin
        c.adrsrc = 1'b1;
        c.memw   = condex;
      end
      S_EXECR: c.alucontrol = alu;
      S_EXECI: begin
        c.alusrcb    = 2'b01;
        c.alucontrol = alu;
      end
      S_ALUWB: wb = condex & ~nowrite;
      S_BRANCH: begin
        c.alusrcb   = 2'b01;
        c.resultsrc = 2'b10;
        c.pcwrite   = condex;
      end
      default: ;
    endcase
    if (rd15) c.pcwrite = c.pcwrite | wb;
    else      c.regw    = wb;
    return c;
  endfunction

  // Condition is evaluated against the flags before this instruction's own update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_flags <= FLAG_RST;
      r_ctrl  <= state_ctrl(S_FETCH, 1'b0, 1'b0, 1'b0, '0);
    end else begin
      r_state <= w_next;
      r_ctrl  <= state_ctrl(w_next, w_condex, w_nowrite, w_rd15, w_aluctl);
      if ((r_state == S_EXECR || r_state == S_EXECI) && w_condex) begin
        if (w_flagw[1]) r_flags[3:2] <= ALUFlags[3:2];
        if (w_flagw[0]) r_flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  assign PCWrite    = r_ctrl.pcwrite & ~reset;
  assign MemW       = r_ctrl.memw    & ~reset;
  assign IRWrite    = r_ctrl.irwrite & ~reset;
  assign RegW       = r_ctrl.regw    & ~reset;
  assign AdrSrc     = r_ctrl.adrsrc;
  assign ALUSrcA    = r_ctrl.alusrca;
  assign ALUSrcB    = r_ctrl.alusrcb;
  assign ResultSrc  = r_ctrl.resultsrc;
  assign ALUControl = r_ctrl.alucontrol;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01) & ~Funct[0], Op == 2'b10};
  assign Illegal    = (r_state == S_DECODE) && !w_legal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control words queued per instruction.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, AdrSrc, MemW, IRWrite, RegW, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [16:0] obs;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0]  m_flags;
  logic [16:0] sb[$];

  typedef enum logic [3:0] {T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_ER, T_EI, T_AW, T_BR} st_e;

  multicycle_controller #(.ALUCTL_W(2), .FLAG_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemW(MemW),
    .IRWrite(IRWrite), .RegW(RegW), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .Illegal(Illegal)
  );

  assign obs = {PCWrite, AdrSrc, MemW, IRWrite, RegW, ALUSrcA, ALUSrcB, ResultSrc,
                ALUControl, Illegal, ImmSrc, RegSrc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cf;         4'h3: return !cf;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cf && !z;   4'h9: return !cf || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [16:0] ev(input st_e s, input logic ce, input logic nw, input logic r15,
                                     input logic [1:0] alu, input logic ill, input logic [1:0] op,
                                     input logic f0);
    logic pcw, adr, mw, irw, rw, asa, il;
    logic [1:0] asb, rs, a;
    {pcw, adr, mw, irw, rw, asa, il} = '0;
    asb = 2'b00; rs = 2'b00; a = 2'b00;
    case (s)
      T_F:   begin irw = 1; pcw = 1; asa = 1; asb = 2'b10; rs = 2'b10; end
      T_D:   begin asa = 1; asb = 2'b10; rs = 2'b10; il = ill; end
      T_MA:  asb = 2'b01;
      T_MR:  adr = 1;
      T_MWB: begin rs = 2'b01; if (r15) pcw = ce; else rw = ce; end
      T_MW:  begin adr = 1; mw = ce; end
      T_ER:  a = alu;
      T_EI:  begin asb = 2'b01; a = alu; end
      T_AW:  begin if (r15) pcw = ce & ~nw; else rw = ce & ~nw; end
      T_BR:  begin asb = 2'b01; rs = 2'b10; pcw = ce; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rw, asa, asb, rs, a, il, op, (op == 2'b01) && !f0, op == 2'b10};
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Called just after a rising edge that enters FETCH; returns just after the edge that re-enters FETCH.
  task automatic instr(input string tag, input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd, input logic [3:0] af, input int rst_at);
    logic ce, legal, nw, r15;
    logic [1:0] alu, fw;
    logic [16:0] e;
    int n;
    Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = af;
    ce = cond_ok(c, m_flags);
    r15 = (rd == 4'd15);
    legal = 1'b1; nw = 1'b0; alu = 2'b00; fw = 2'b00;
    if (op == 2'b11) legal = 1'b0;
    else if (op == 2'b00) begin
      case (f[4:1])
        4'b0100: begin alu = 2'b00; fw = f[0] ? 2'b11 : 2'b00; end
        4'b0010: begin alu = 2'b01; fw = f[0] ? 2'b11 : 2'b00; end
        4'b0000: begin alu = 2'b10; fw = f[0] ? 2'b10 : 2'b00; end
        4'b1100: begin alu = 2'b11; fw = f[0] ? 2'b10 : 2'b00; end
        4'b1010: begin alu = 2'b01; fw = 2'b11; nw = 1'b1; legal = f[0]; end
        4'b1000: begin alu = 2'b10; fw = 2'b10; nw = 1'b1; legal = f[0]; end
        default: legal = 1'b0;
      endcase
    end
    sb.push_back(ev(T_F, ce, nw, r15, alu, 1'b0, op, f[0]));
    sb.push_back(ev(T_D, ce, nw, r15, alu, !legal, op, f[0]));
    if (legal) begin
      case (op)
        2'b00: begin
          sb.push_back(ev(f[5] ? T_EI : T_ER, ce, nw, r15, alu, 1'b0, op, f[0]));
          sb.push_back(ev(T_AW, ce, nw, r15, alu, 1'b0, op, f[0]));
        end
        2'b01: begin
          sb.push_back(ev(T_MA, ce, nw, r15, alu, 1'b0, op, f[0]));
          if (f[0]) begin
            sb.push_back(ev(T_MR, ce, nw, r15, alu, 1'b0, op, f[0]));
            sb.push_back(ev(T_MWB, ce, nw, r15, alu, 1'b0, op, f[0]));
          end else begin
            sb.push_back(ev(T_MW, ce, nw, r15, alu, 1'b0, op, f[0]));
          end
        end
        default: sb.push_back(ev(T_BR, ce, nw, r15, alu, 1'b0, op, f[0]));
      endcase
      if (op == 2'b00 && ce) begin
        if (fw[1]) m_flags[3:2] = af[3:2];
        if (fw[0]) m_flags[1:0] = af[1:0];
      end
    end
    n = 0;
    while (sb.size() > 0) begin
      if (n == rst_at) reset = 1'b1;
      @(negedge clk);
      e = sb.pop_front();
      // Write enables are held low for the whole reset cycle
      if (n == rst_at) e = e & ~17'h17000;
      check($sformatf("%s cyc%0d", tag, n), obs, e);
      @(posedge clk);
      #1;
      if (n == rst_at) begin
        reset = 1'b0;
        sb.delete();
        m_flags = 4'b0000;
      end
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; Cond = 4'h0; Op = 2'b00; Funct = 6'h00; Rd = 4'h0; ALUFlags = 4'h0;
    m_flags = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_fetch", obs, ev(T_F, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0) & ~17'h17000);
    @(posedge clk);
    #1;
    reset = 1'b0;

    instr("adds_imm",  4'hE, 2'b00, 6'b101001, 4'd1,  4'b0100, -1);
    instr("beq_taken", 4'h0, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    instr("subs_reg",  4'hE, 2'b00, 6'b000101, 4'd3,  4'b1000, -1);
    instr("beq_not",   4'h0, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    instr("bmi",       4'h4, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    instr("ldr",       4'hE, 2'b01, 6'b011001, 4'd2,  4'b0000, -1);
    instr("ldr_pc",    4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000, -1);
    instr("cmp",       4'hE, 2'b00, 6'b010101, 4'd4,  4'b0111, -1);
    instr("tst",       4'hE, 2'b00, 6'b010001, 4'd4,  4'b1000, -1);
    instr("bcs",       4'h2, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    instr("bvs",       4'h6, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    instr("bge",       4'hA, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    instr("bhi",       4'h8, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    instr("adds_z",    4'hE, 2'b00, 6'b101001, 4'd1,  4'b0100, -1);
    instr("str_ne",    4'h1, 2'b01, 6'b011000, 4'd5,  4'b0000, -1);
    instr("str_al",    4'hE, 2'b01, 6'b011000, 4'd5,  4'b0000, -1);
    instr("op11",      4'hE, 2'b11, 6'b000000, 4'd0,  4'b0000, -1);
    instr("eor_w2",    4'hE, 2'b00, 6'b000011, 4'd6,  4'b0000, -1);
    instr("cmp_nos",   4'hE, 2'b00, 6'b010100, 4'd6,  4'b0000, -1);
    instr("adds_nv",   4'hF, 2'b00, 6'b101001, 4'd7,  4'b1011, -1);
    instr("beq_keep",  4'h0, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    instr("add_pc",    4'hE, 2'b00, 6'b001000, 4'd15, 4'b0000, -1);
    instr("str_rst",   4'hE, 2'b01, 6'b011000, 4'd5,  4'b0000, 3);
    instr("beq_post",  4'h0, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    instr("bne_post",  4'h1, 2'b10, 6'b100000, 4'd0,  4'b0000, -1);
    instr("orr",       4'hE, 2'b00, 6'b011000, 4'd8,  4'b0000, -1);
    instr("and",       4'hE, 2'b00, 6'b000000, 4'd9,  4'b0000, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
